// File: rtl/obf_key_loader.sv
// rtl/obf_key_loader.sv - bit-serial key loader driving the parallel key bus of a logic-locked netlist
// Optional even-parity frame check is enabled by defining OBF_KEY_PARITY_EN.
module obf_key_loader #(
    parameter int               KEY_W   = 2,
    parameter logic [KEY_W-1:0] RST_KEY = {KEY_W{1'b1}},
    parameter int               TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit,
    input  logic             key_bit_vld,
    input  logic             key_lock,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic             locked
);

`ifdef OBF_KEY_PARITY_EN
    localparam int FRAME_W = KEY_W + 1;
`else
    localparam int FRAME_W = KEY_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               locked_q, locked_d;
    logic               chk_pass;

`ifdef OBF_KEY_PARITY_EN
    // Data bits plus the even-parity bit must XOR to zero.
    assign chk_pass = ~(^sr_q);
`else
    assign chk_pass = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        tmo_d    = tmo_q;
        key_d    = key_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        err_d    = err_q;
        locked_d = locked_q;
        case (state_q)
            ST_IDLE: begin
                // A legal lock beats a simultaneous frame start.
                if (key_lock && valid_q) begin
                    state_d  = ST_FROZEN;
                    locked_d = 1'b1;
                end else if (key_start) begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    sr_d    = '0;
                    bcnt_d  = '0;
                    tmo_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (key_start) begin
                    err_d  = 1'b0;
                    sr_d   = '0;
                    bcnt_d = '0;
                    tmo_d  = '0;
                end else if (key_bit_vld) begin
                    sr_d              = sr_q >> 1;
                    sr_d[FRAME_W-1]   = key_bit;
                    bcnt_d            = bcnt_q + 1'b1;
                    tmo_d             = '0;
                    if (bcnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_q == LAST_TMO) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (chk_pass) begin
                    key_d   = sr_q[KEY_W-1:0];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_FROZEN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            bcnt_q   <= '0;
            tmo_q    <= '0;
            key_q    <= RST_KEY;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            tmo_q    <= tmo_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign key_out   = key_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// tb/tb_obf_key_loader.sv - table-driven bench for obf_key_loader (KEY_W=2, TIMEOUT=16)
// Expectations follow OBF_KEY_PARITY_EN when it is defined.
module tb_obf_key_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_bit_vld = 1'b0;
    logic       key_lock = 1'b0;
    logic [1:0] key_out;
    logic       key_valid;
    logic       busy;
    logic       err;
    logic       locked;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic       st;
        logic       b;
        logic       vld;
        logic       lk;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    obf_key_loader #(
        .KEY_W  (2),
        .RST_KEY(2'b11),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_bit    (key_bit),
        .key_bit_vld(key_bit_vld),
        .key_lock   (key_lock),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp packs {key_out, key_valid, busy, err, locked}
    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {key_out, key_valid, busy, err, locked};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got key=%b vld=%b busy=%b err=%b lck=%b, expected key=%b vld=%b busy=%b err=%b lck=%b",
                     name, got[5:4], got[3], got[2], got[1], got[0],
                     exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic v(input string name, input logic st, input logic b, input logic vld,
                     input logic lk, input logic [1:0] k, input logic kv, input logic bz,
                     input logic e, input logic l);
        vec_t r;
        r.name = name;
        r.st   = st;
        r.b    = b;
        r.vld  = vld;
        r.lk   = lk;
        r.exp  = {k, kv, bz, e, l};
        tbl.push_back(r);
    endtask

    initial begin
        // Good load of 00
        v("g00_start", 1, 0, 0, 0, 2'b11, 0, 1, 0, 0);
        v("g00_b0",    0, 0, 1, 0, 2'b11, 0, 1, 0, 0);
        v("g00_b1",    0, 0, 1, 0, 2'b11, 0, 1, 0, 0);
`ifdef OBF_KEY_PARITY_EN
        v("g00_par",   0, 0, 1, 0, 2'b11, 0, 1, 0, 0);
`endif
        v("g00_load",  0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        // Bits 0,1 load 2'b10
        v("l10_start", 1, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        v("l10_b0",    0, 0, 1, 0, 2'b00, 1, 1, 0, 0);
        v("l10_b1",    0, 1, 1, 0, 2'b00, 1, 1, 0, 0);
`ifdef OBF_KEY_PARITY_EN
        v("l10_par",   0, 1, 1, 0, 2'b00, 1, 1, 0, 0);
`endif
        v("l10_load",  0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
`ifdef OBF_KEY_PARITY_EN
        v("perr_start", 1, 0, 0, 0, 2'b10, 1, 1, 0, 0);
        v("perr_b0",    0, 1, 1, 0, 2'b10, 1, 1, 0, 0);
        v("perr_b1",    0, 0, 1, 0, 2'b10, 1, 1, 0, 0);
        v("perr_par",   0, 0, 1, 0, 2'b10, 1, 1, 0, 0);
        v("perr_chk",   0, 0, 0, 0, 2'b10, 1, 0, 1, 0);
`endif
        // Timeout after one bit
        v("tmo_start", 1, 0, 0, 0, 2'b10, 1, 1, 0, 0);
        v("tmo_b0",    0, 1, 1, 0, 2'b10, 1, 1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) v($sformatf("tmo_idle%0d", i), 0, 0, 0, 0, 2'b10, 1, 1, 0, 0);
            else        v("tmo_idle16",               0, 0, 0, 0, 2'b10, 1, 0, 1, 0);
        end
        v("tmo_after", 0, 0, 0, 0, 2'b10, 1, 0, 1, 0);
        // Restart discards the earlier bit; start also clears err
        v("rs_start",   1, 0, 0, 0, 2'b10, 1, 1, 0, 0);
        v("rs_b0",      0, 0, 1, 0, 2'b10, 1, 1, 0, 0);
        v("rs_restart", 1, 0, 0, 0, 2'b10, 1, 1, 0, 0);
        v("rs_b1",      0, 1, 1, 0, 2'b10, 1, 1, 0, 0);
        v("rs_b2",      0, 1, 1, 0, 2'b10, 1, 1, 0, 0);
`ifdef OBF_KEY_PARITY_EN
        v("rs_par",     0, 0, 1, 0, 2'b10, 1, 1, 0, 0);
`endif
        v("rs_load",    0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        // key_start with key_bit_vld in IDLE: the bit is dropped
        v("sim_start", 1, 1, 1, 0, 2'b11, 1, 1, 0, 0);
        v("sim_b0",    0, 0, 1, 0, 2'b11, 1, 1, 0, 0);
        v("sim_b1",    0, 0, 1, 0, 2'b11, 1, 1, 0, 0);
`ifdef OBF_KEY_PARITY_EN
        v("sim_par",   0, 0, 1, 0, 2'b11, 1, 1, 0, 0);
`endif
        v("sim_load",  0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        // key_lock during SHIFT is ignored; frame loads 2'b01
        v("lks_start", 1, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        v("lks_b0",    0, 1, 1, 1, 2'b00, 1, 1, 0, 0);
        v("lks_b1",    0, 0, 1, 0, 2'b00, 1, 1, 0, 0);
`ifdef OBF_KEY_PARITY_EN
        v("lks_par",   0, 1, 1, 0, 2'b00, 1, 1, 0, 0);
`endif
        v("lks_load",  0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        // Lock beats simultaneous start; FROZEN ignores further frames
        v("lk_lock",   1, 0, 0, 1, 2'b01, 1, 0, 0, 1);
        v("fz_start",  1, 0, 0, 0, 2'b01, 1, 0, 0, 1);
        v("fz_b0",     0, 0, 1, 0, 2'b01, 1, 0, 0, 1);
        v("fz_b1",     0, 0, 1, 0, 2'b01, 1, 0, 0, 1);
        v("fz_b2",     0, 0, 1, 1, 2'b01, 1, 0, 0, 1);
        v("fz_idle",   0, 0, 0, 0, 2'b01, 1, 0, 0, 1);

        rst = 1'b1;
        step();
        step();
        chk("reset", {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        key_lock = 1'b1;
        step();
        key_lock = 1'b0;
        chk("lock_without_key", {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            key_start   = tbl[i].st;
            key_bit     = tbl[i].b;
            key_bit_vld = tbl[i].vld;
            key_lock    = tbl[i].lk;
            step();
            chk(tbl[i].name, tbl[i].exp);
        end
        key_start   = 1'b0;
        key_bit_vld = 1'b0;
        key_lock    = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_from_frozen", {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});

        key_start = 1'b1;
        step();
        key_start   = 1'b0;
        key_bit     = 1'b1;
        key_bit_vld = 1'b1;
        step();
        key_bit_vld = 1'b0;
        chk("midframe_busy", {2'b11, 1'b0, 1'b1, 1'b0, 1'b0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_midframe", {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
